// File: rtl/ddr4_pkg.sv
// Shared DDR4 command encodings, timing defaults and error bit positions.
// Used by both the controller side and the responder model.
package ddr4_pkg;

    localparam int CL_DEF  = 11;
    localparam int CWL_DEF = 11;
    localparam int BL_DEF  = 8;

    // {RAS,CAS,WE,A10} codes when ACT_n is high
    localparam logic [3:0] CODE_RD   = 4'b1010;
    localparam logic [3:0] CODE_WR   = 4'b1000;
    localparam logic [3:0] CODE_PRE  = 4'b0100;
    localparam logic [3:0] CODE_PREA = 4'b0101;
    localparam logic [3:0] CODE_ZQCL = 4'b1101;
    localparam logic [2:0] CODE_REF  = 3'b001;
    localparam logic [2:0] CODE_MRS  = 3'b000;
    localparam logic [2:0] CODE_NOP  = 3'b111;

    localparam int ERR_CLOSED   = 0;
    localparam int ERR_ACT_OPEN = 1;
    localparam int ERR_REF_OPEN = 2;
    localparam int ERR_RD_BUSY  = 3;
    localparam int ERR_WR_BUSY  = 4;
    localparam int ERR_W        = 5;

    typedef enum logic [3:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_RD,
        CMD_WR,
        CMD_PRE,
        CMD_PREA,
        CMD_ZQCL,
        CMD_REF,
        CMD_MRS
    } cmd_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_LAT,
        R_BURST
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_LAT,
        W_BURST
    } wr_state_e;

    function automatic logic [5:0] word_idx(
        input logic [1:0] bg,
        input logic [1:0] ba,
        input logic [1:0] col
    );
        return {bg, ba, col};
    endfunction

endpackage

// File: rtl/ddr4_resp_if.sv
// Command/address and data pins between a DDR4 controller and the responder.
// The controller is the master; the responder drives only the read data side.
interface ddr4_resp_if;

    logic        drst_n;
    logic        cke;
    logic        dcs_n;
    logic        dact_n;
    logic [16:0] da;
    logic [1:0]  dbg;
    logic [1:0]  dba;
    logic [3:0]  dq_in;
    logic [3:0]  dq_out;
    logic        dq_oe;
    logic        dqs_t;
    logic        dqs_c;

    modport master (
        output drst_n, cke, dcs_n, dact_n,
        output da, dbg, dba, dq_in,
        input  dq_out, dq_oe, dqs_t, dqs_c
    );

    modport slave (
        input  drst_n, cke, dcs_n, dact_n,
        input  da, dbg, dba, dq_in,
        output dq_out, dq_oe, dqs_t, dqs_c
    );

endinterface

// File: rtl/ddr4_resp_decode.sv
// Combinational DDR4 command decode; anything unrecognised or
// arriving while deselected, clock-disabled or in device reset is a NOP.
module ddr4_resp_decode
    import ddr4_pkg::*;
(
    input  logic       cke,
    input  logic       dcs_n,
    input  logic       drst_n,
    input  logic       dact_n,
    input  logic [3:0] code,
    output cmd_e       cmd
);

    always_comb begin
        cmd = CMD_NOP;
        if (cke && !dcs_n && drst_n) begin
            if (!dact_n) begin
                cmd = CMD_ACT;
            end else begin
                unique casez (code)
                    CODE_RD:          cmd = CMD_RD;
                    CODE_WR:          cmd = CMD_WR;
                    CODE_PRE:         cmd = CMD_PRE;
                    CODE_PREA:        cmd = CMD_PREA;
                    CODE_ZQCL:        cmd = CMD_ZQCL;
                    {CODE_REF, 1'b?}: cmd = CMD_REF;
                    {CODE_MRS, 1'b?}: cmd = CMD_MRS;
                    {CODE_NOP, 1'b?}: cmd = CMD_NOP;
                    default:          cmd = CMD_NOP;
                endcase
            end
        end
    end

endmodule

// File: rtl/ddr4_resp.sv
// DDR4 device responder: bank table, 64x32 storage, and independent
// read/write burst engines with fixed CL/CWL latency.
module ddr4_resp
    import ddr4_pkg::*;
#(
    parameter int CL  = CL_DEF,
    parameter int CWL = CWL_DEF,
    parameter int BL  = BL_DEF
) (
    input  logic        clkin,
    input  logic        crst,
    ddr4_resp_if.slave  bus,
    output logic [15:0] bank_open,
    output logic [4:0]  err,
    output logic [15:0] ref_cnt,
    output logic [2:0]  mrs_cnt
);

    localparam logic [3:0] RLAT_END = 4'(CL - 1);
    localparam logic [3:0] WLAT_END = 4'(CWL - 2);
    localparam logic [3:0] BEAT_END = 4'(BL - 1);

    cmd_e        cmd;
    logic        clr;
    logic [3:0]  bank;
    logic [5:0]  idx;

    logic [31:0] mem [64];
    logic [16:0] row_q [16];

    rd_state_e   rstate, rstate_n;
    logic [3:0]  rcnt, rcnt_n;
    logic [31:0] rword;
    logic        rd_go;

    wr_state_e   wstate, wstate_n;
    logic [3:0]  wcnt, wcnt_n;
    logic [31:0] wbuf;
    logic [5:0]  widx;
    logic        wr_go;
    logic        wr_beat;
    logic        w_commit;

    ddr4_resp_decode u_dec (
        .cke    (bus.cke),
        .dcs_n  (bus.dcs_n),
        .drst_n (bus.drst_n),
        .dact_n (bus.dact_n),
        .code   ({bus.da[16:14], bus.da[10]}),
        .cmd    (cmd)
    );

    assign clr  = crst | ~bus.drst_n;
    assign bank = {bus.dbg, bus.dba};
    assign idx  = word_idx(bus.dbg, bus.dba, bus.da[4:3]);

    // Read engine
    always_comb begin
        rstate_n = rstate;
        rcnt_n   = rcnt;
        rd_go    = 1'b0;
        unique case (rstate)
            R_IDLE: begin
                if (cmd == CMD_RD) begin
                    rstate_n = R_LAT;
                    rcnt_n   = '0;
                    rd_go    = 1'b1;
                end
            end
            R_LAT: begin
                if (rcnt == RLAT_END) begin
                    rstate_n = R_BURST;
                    rcnt_n   = '0;
                end else begin
                    rcnt_n = rcnt + 4'd1;
                end
            end
            R_BURST: begin
                if (rcnt == BEAT_END) begin
                    rstate_n = R_IDLE;
                end else begin
                    rcnt_n = rcnt + 4'd1;
                end
            end
            default: rstate_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (clr) begin
            rstate <= R_IDLE;
            rcnt   <= '0;
            rword  <= '0;
        end else begin
            rstate <= rstate_n;
            rcnt   <= rcnt_n;
            if (rd_go) rword <= mem[idx];
        end
    end

    assign bus.dq_oe  = (rstate == R_BURST);
    assign bus.dq_out = bus.dq_oe ? rword[{rcnt[2:0], 2'b00} +: 4] : 4'h0;
    assign bus.dqs_t  = bus.dq_oe & ~rcnt[0];
    assign bus.dqs_c  = bus.dq_oe & rcnt[0];

    // Write engine: latency phase ends one edge early so beat 0 lands at T+CWL
    always_comb begin
        wstate_n = wstate;
        wcnt_n   = wcnt;
        wr_go    = 1'b0;
        wr_beat  = 1'b0;
        w_commit = 1'b0;
        unique case (wstate)
            W_IDLE: begin
                if (cmd == CMD_WR) begin
                    wstate_n = W_LAT;
                    wcnt_n   = '0;
                    wr_go    = 1'b1;
                end
            end
            W_LAT: begin
                if (wcnt == WLAT_END) begin
                    wstate_n = W_BURST;
                    wcnt_n   = '0;
                end else begin
                    wcnt_n = wcnt + 4'd1;
                end
            end
            W_BURST: begin
                wr_beat = 1'b1;
                if (wcnt == BEAT_END) begin
                    wstate_n = W_IDLE;
                    w_commit = 1'b1;
                end else begin
                    wcnt_n = wcnt + 4'd1;
                end
            end
            default: wstate_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (clr) begin
            wstate <= W_IDLE;
            wcnt   <= '0;
            wbuf   <= '0;
            widx   <= '0;
        end else begin
            wstate <= wstate_n;
            wcnt   <= wcnt_n;
            if (wr_go) widx <= idx;
            if (wr_beat) wbuf[{wcnt[2:0], 2'b00} +: 4] <= bus.dq_in;
        end
    end

    // Last beat goes straight from the pins into the committed word
    always_ff @(posedge clkin) begin
        if (crst) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (w_commit && bus.drst_n) begin
            mem[widx] <= {bus.dq_in, wbuf[27:0]};
        end
    end

    always_ff @(posedge clkin) begin
        if (cmd == CMD_ACT) row_q[bank] <= bus.da;
    end

    always_ff @(posedge clkin) begin
        if (clr) begin
            bank_open <= '0;
            err       <= '0;
            ref_cnt   <= '0;
            mrs_cnt   <= '0;
        end else begin
            unique case (cmd)
                CMD_ACT: begin
                    if (bank_open[bank]) err[ERR_ACT_OPEN] <= 1'b1;
                    bank_open[bank] <= 1'b1;
                end
                CMD_PRE:  bank_open[bank] <= 1'b0;
                CMD_PREA: bank_open <= '0;
                CMD_REF: begin
                    ref_cnt <= ref_cnt + 16'd1;
                    if (|bank_open) err[ERR_REF_OPEN] <= 1'b1;
                end
                CMD_MRS: begin
                    if (mrs_cnt != 3'd7) mrs_cnt <= mrs_cnt + 3'd1;
                end
                CMD_RD: begin
                    if (!bank_open[bank]) err[ERR_CLOSED] <= 1'b1;
                    if (rstate != R_IDLE) err[ERR_RD_BUSY] <= 1'b1;
                end
                CMD_WR: begin
                    if (!bank_open[bank]) err[ERR_CLOSED] <= 1'b1;
                    if (wstate != W_IDLE) err[ERR_WR_BUSY] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ddr4_resp.md
DDR4_RESP -- requirements
Module: ddr4_resp

Interface
REQ-001 Parameters SHALL be: CL 11, read latency in clocks from RD sample to first beat; CWL 11, write latency from WR sample to first beat; BL 8, beats per burst, fixed.
REQ-002 clkin  in  1  sole clock; all logic on the rising edge.
REQ-003 crst  in  1  reset, synchronous, active-high.
REQ-004 drst_n  in  1  device reset from the controller, active-low.
REQ-005 cke  in  1  clock enable; commands are ignored while cke=0.
REQ-006 dcs_n  in  1  chip select, active-low; dcs_n=1 means DES.
REQ-007 dact_n  in  1  activate, active-low.
REQ-008 da  in  17  address and command pins; [16:14] are RAS/CAS/WE and [10] is A10 when dact_n=1.
REQ-009 dbg, dba  in  2 each  bank group and bank.
REQ-010 dq_in  in  4  write data beat.
REQ-011 dq_out  out  4  read data beat.
REQ-012 dq_oe  out  1  read driver enable.
REQ-013 dqs_t, dqs_c  out  1 each  read strobe pair.
REQ-014 bank_open  out  16  per-bank open flag, indexed {dbg,dba}.
REQ-015 err  out  5  sticky error flags: [0] RD/WR to closed bank, [1] ACT to open bank, [2] REF with any bank open, [3] RD while a read is pending, [4] WR while a write is pending.
REQ-016 ref_cnt  out  16  count of accepted REF commands, wraps at 2^16.
REQ-017 mrs_cnt  out  3  count of accepted MRS commands, saturates at 7.

Function
REQ-018 Decoding SHALL happen only when cke=1, dcs_n=0 and drst_n=1.
- dact_n=0 is ACT; the row is da[16:0].
- Otherwise {da[16:14],da[10]} selects: 1010 RD, 1000 WR, 0100 PRE, 0101 PREA, 1101 ZQCL, 001x REF, 000x MRS, 111x NOP.
- Any other code is NOP.
REQ-019 ACT SHALL set the addressed bank's open flag and store its row; ACT to an already open bank sets err[1] and reloads the row.
REQ-020 PRE SHALL clear the addressed bank's flag; PREA SHALL clear all 16 flags; PRE to a closed bank is legal.
REQ-021 REF SHALL increment ref_cnt; if any bank is open it also sets err[2]. ZQCL SHALL have no effect. MRS SHALL increment mrs_cnt.
REQ-022 RD or WR to a closed bank SHALL set err[0], and the burst still executes.
REQ-023 Storage SHALL be 64 x 32-bit words indexed by {dbg,dba,da[4:3]}; the row and other column bits are ignored, so aliasing is intended.
REQ-024 Read path FSM SHALL have states R_IDLE -> R_LAT -> R_BURST -> R_IDLE.
- RD sampled at edge T latches the word.
- dq_oe=1 for edges T+CL .. T+CL+7.
- Beat i SHALL be word[4i+3:4i].
- dqs_t toggles each beat starting at 1; dqs_c = ~dqs_t while dq_oe=1; both are 0 otherwise.
REQ-025 Write path FSM SHALL have states W_IDLE -> W_LAT -> W_BURST -> W_IDLE.
- WR sampled at edge T sets beat i = dq_in at edge T+CWL+i.
- The whole word SHALL commit to storage at edge T+CWL+7.
- A read of the same index issued before the commit returns the old data.
REQ-026 RD arriving while the read FSM is not R_IDLE SHALL set err[3] and be dropped; WR arriving while the write FSM is not W_IDLE SHALL set err[4] and be dropped. Read and write paths SHALL run concurrently and independently.
REQ-027 drst_n=0 SHALL, on each edge:
- clear bank_open, err, ref_cnt and mrs_cnt;
- return both FSMs to idle with dq_oe=0.
- Storage SHALL be retained.

Reset
REQ-028 crst=1 SHALL produce the same state as REQ-027, and SHALL also zero all storage words, within one clock; all outputs read 0 on the following edge.
REQ-029 crst asserted mid-burst SHALL abort the burst; an aborted write SHALL not commit.

Structure
REQ-030 A shared package (ddr4_pkg) SHALL hold the command encodings, the CL/CWL/BL defaults and the err bit indices, for use by both controller and responder.
REQ-031 One sub-module, ddr4_resp_decode, SHALL hold the combinational command decode; the bank table, FSMs and storage stay in ddr4_resp.

Verification
REQ-032 ACT bg1 ba2 row 0x1ABCD, then RD col 0x008 with storage preset -> bank_open[6]=1; dq_oe high exactly at edges T+11..T+18; err=0.
REQ-033 WR bg0 ba0 col 0, dq_in beats 1..8 at T+11..T+18, then RD -> read beats return 1..8 and dqs toggles 8 times.
REQ-034 RD to a closed bank 3 -> err[0]=1, and the burst still occurs.
REQ-035 ACT bank 5, then REF -> err[2]=1 and ref_cnt=1; PREA then REF -> ref_cnt=2 and bank_open=0.
REQ-036 Second RD 4 cycles after the first -> err[3]=1, a single burst only; crst at edge T+13 -> dq_oe=0 next edge and err=0.
REQ-037 8 MRS commands -> mrs_cnt=7; commands with cke=0 -> no state change.
